// File: rtl/hdmi_rx_pkg.sv
// Shared constants, FSM state type and field structs for the HDMI receive InfoFrame path.
package hdmi_rx_pkg;

  localparam logic [7:0] PKT_TYPE_NULL = 8'h00;
  localparam logic [7:0] PKT_TYPE_AVI  = 8'h82;
  localparam logic [7:0] PKT_TYPE_SPD  = 8'h83;
  localparam logic [7:0] AVI_VERSION   = 8'h02;
  localparam logic [7:0] SPD_VERSION   = 8'h01;
  localparam logic [4:0] AVI_MIN_LEN   = 5'd13;
  localparam logic [4:0] SPD_MIN_LEN   = 5'd25;
  localparam logic [4:0] IF_MAX_LEN    = 5'd27;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SUB0,
    ST_SUB1,
    ST_SUB2,
    ST_SUB3,
    ST_COMMIT
  } rx_state_t;

  typedef struct packed {
    logic [6:0] vic;
    logic [1:0] color_space;
    logic [1:0] picture_aspect;
    logic       it_content;
  } avi_fields_t;

  function automatic logic is_infoframe(input logic [7:0] pkt_type, input logic spd_en);
    if (pkt_type == PKT_TYPE_NULL) return 1'b0;
    return (pkt_type == PKT_TYPE_AVI) || (spd_en && (pkt_type == PKT_TYPE_SPD));
  endfunction

  // Payload byte PB(n) lives in subpacket n/7, byte lane n%7.
  function automatic logic [7:0] pb_byte(input logic [3:0][55:0] subs, input int unsigned n);
    return subs[2'(n / 7)][6'((n % 7) * 8) +: 8];
  endfunction

endpackage

// File: rtl/info_frame_checksum.sv
// Serial InfoFrame checksum: loads the header byte sum, then adds one subpacket per cycle,
// skipping payload bytes whose index exceeds the frame length.
module info_frame_checksum (
  input  logic        clk_pixel,
  input  logic        reset,
  input  logic        i_load_hdr,
  input  logic [23:0] i_header,
  input  logic        i_add,
  input  logic [1:0]  i_sub_idx,
  input  logic [55:0] i_sub,
  input  logic [4:0]  i_length,
  output logic [7:0]  o_sum
);

  logic [7:0] r_acc;
  logic [7:0] w_sub_sum;
  logic [4:0] w_base;

  always_comb begin
    w_base    = {i_sub_idx, 3'b000} - {3'b000, i_sub_idx};
    w_sub_sum = '0;
    for (int unsigned k = 0; k < 7; k++) begin
      if ((w_base + 5'(k)) <= i_length) begin
        w_sub_sum = w_sub_sum + i_sub[8*k +: 8];
      end
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_acc <= '0;
    end else if (i_load_hdr) begin
      r_acc <= i_header[7:0] + i_header[15:8] + i_header[23:16];
    end else if (i_add) begin
      r_acc <= r_acc + w_sub_sum;
    end
  end

  assign o_sum = r_acc;

endmodule

// File: rtl/info_frame_receiver.sv
// Sink-side AVI/SPD InfoFrame decoder with checksum validation and per-type staleness tracking.
// SPD decoding is enabled by defining INFO_FRAME_RX_SPD_EN.
module info_frame_receiver
  import hdmi_rx_pkg::*;
#(
  parameter int unsigned STALE_FIELDS = 2,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic                 video_field_end,
  input  logic                 packet_valid,
  input  logic [23:0]          header,
  input  logic [3:0][55:0]     sub,
  output logic                 busy,
  output logic                 avi_update,
  output logic                 spd_update,
  output logic                 avi_valid,
  output logic                 spd_valid,
  output logic                 avi_stale,
  output logic                 spd_stale,
  output logic [6:0]           avi_vic,
  output logic [1:0]           avi_color_space,
  output logic [1:0]           avi_picture_aspect,
  output logic                 avi_it_content,
  output logic [63:0]          spd_vendor,
  output logic [127:0]         spd_product,
  output logic [7:0]           spd_source_info,
  output logic [CNT_WIDTH-1:0] checksum_err_count,
  output logic [CNT_WIDTH-1:0] drop_count
);

`ifdef INFO_FRAME_RX_SPD_EN
  localparam logic SPD_EN = 1'b1;
`else
  localparam logic SPD_EN = 1'b0;
`endif
  localparam logic [3:0] STALE_LIMIT = 4'(STALE_FIELDS);

  rx_state_t              r_state;
  logic                   r_busy;
  logic [23:0]            r_hdr;
  logic [3:0][55:0]       r_sub;
  avi_fields_t            r_avi;
  logic                   r_avi_valid;
  logic                   r_avi_update;
  logic [3:0]             r_avi_fcnt;
  logic [CNT_WIDTH-1:0]   r_err;
  logic [CNT_WIDTH-1:0]   r_drop;

  logic                   w_decodable;
  logic                   w_add;
  logic [1:0]             w_sub_idx;
  logic [7:0]             w_sum;
  logic [7:0]             w_type;
  logic [7:0]             w_ver;
  logic [4:0]             w_len;
  logic                   w_good;
  logic                   w_avi_good;

  assign w_decodable = is_infoframe(header[7:0], SPD_EN);
  assign w_type      = r_hdr[7:0];
  assign w_ver       = r_hdr[15:8];
  assign w_len       = r_hdr[20:16];

  always_comb begin
    w_add     = 1'b1;
    w_sub_idx = 2'd0;
    case (r_state)
      ST_SUB0: w_sub_idx = 2'd0;
      ST_SUB1: w_sub_idx = 2'd1;
      ST_SUB2: w_sub_idx = 2'd2;
      ST_SUB3: w_sub_idx = 2'd3;
      default: w_add     = 1'b0;
    endcase
  end

  info_frame_checksum u_checksum (
    .clk_pixel  (clk_pixel),
    .reset      (reset),
    .i_load_hdr (r_state == ST_HDR),
    .i_header   (r_hdr),
    .i_add      (w_add),
    .i_sub_idx  (w_sub_idx),
    .i_sub      (r_sub[w_sub_idx]),
    .i_length   (w_len),
    .o_sum      (w_sum)
  );

  assign w_good = (w_sum == 8'h00) && (w_len <= IF_MAX_LEN) &&
                  (((w_type == PKT_TYPE_AVI) && (w_ver == AVI_VERSION) && (w_len >= AVI_MIN_LEN)) ||
                   (SPD_EN && (w_type == PKT_TYPE_SPD) && (w_ver == SPD_VERSION) && (w_len >= SPD_MIN_LEN)));
  assign w_avi_good = (r_state == ST_COMMIT) && w_good && (w_type == PKT_TYPE_AVI);

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_busy       <= 1'b0;
      r_hdr        <= '0;
      r_sub        <= '0;
      r_avi        <= '0;
      r_avi_valid  <= 1'b0;
      r_avi_update <= 1'b0;
      r_avi_fcnt   <= '0;
      r_err        <= '0;
      r_drop       <= '0;
    end else begin
      r_avi_update <= 1'b0;
      if (packet_valid && w_decodable && (r_state != ST_IDLE) && (r_drop != '1)) begin
        r_drop <= r_drop + CNT_WIDTH'(1);
      end
      case (r_state)
        ST_IDLE: begin
          if (packet_valid && w_decodable) begin
            r_hdr   <= header;
            r_sub   <= sub;
            r_busy  <= 1'b1;
            r_state <= ST_HDR;
          end
        end
        ST_HDR:  r_state <= ST_SUB0;
        ST_SUB0: r_state <= ST_SUB1;
        ST_SUB1: r_state <= ST_SUB2;
        ST_SUB2: r_state <= ST_SUB3;
        ST_SUB3: r_state <= ST_COMMIT;
        ST_COMMIT: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
          if (w_avi_good) begin
            r_avi.vic            <= r_sub[0][38:32];
            r_avi.color_space    <= r_sub[0][14:13];
            r_avi.picture_aspect <= r_sub[0][21:20];
            r_avi.it_content     <= r_sub[0][31];
            r_avi_valid          <= 1'b1;
            r_avi_update         <= 1'b1;
          end else if (!w_good && (r_err != '1)) begin
            r_err <= r_err + CNT_WIDTH'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
      // A commit in the same cycle as a field end restarts the count from zero.
      if (w_avi_good) begin
        r_avi_fcnt <= '0;
      end else if (video_field_end && (r_avi_fcnt != STALE_LIMIT)) begin
        r_avi_fcnt <= r_avi_fcnt + 4'd1;
      end
    end
  end

  assign busy               = r_busy;
  assign avi_update         = r_avi_update;
  assign avi_valid          = r_avi_valid;
  assign avi_stale          = (r_avi_fcnt == STALE_LIMIT);
  assign avi_vic            = r_avi.vic;
  assign avi_color_space    = r_avi.color_space;
  assign avi_picture_aspect = r_avi.picture_aspect;
  assign avi_it_content     = r_avi.it_content;
  assign checksum_err_count = r_err;
  assign drop_count         = r_drop;

`ifdef INFO_FRAME_RX_SPD_EN
  logic         r_spd_valid;
  logic         r_spd_update;
  logic [3:0]   r_spd_fcnt;
  logic [63:0]  r_spd_vendor;
  logic [127:0] r_spd_product;
  logic [7:0]   r_spd_source;
  logic         w_spd_good;

  assign w_spd_good = (r_state == ST_COMMIT) && w_good && (w_type == PKT_TYPE_SPD);

  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      r_spd_valid   <= 1'b0;
      r_spd_update  <= 1'b0;
      r_spd_fcnt    <= '0;
      r_spd_vendor  <= '0;
      r_spd_product <= '0;
      r_spd_source  <= '0;
    end else begin
      r_spd_update <= w_spd_good;
      if (w_spd_good) begin
        r_spd_valid <= 1'b1;
        for (int unsigned j = 0; j < 8; j++) begin
          r_spd_vendor[8*j +: 8] <= pb_byte(r_sub, 1 + j);
        end
        for (int unsigned j = 0; j < 16; j++) begin
          r_spd_product[8*j +: 8] <= pb_byte(r_sub, 9 + j);
        end
        r_spd_source <= pb_byte(r_sub, 25);
      end
      if (w_spd_good) begin
        r_spd_fcnt <= '0;
      end else if (video_field_end && (r_spd_fcnt != STALE_LIMIT)) begin
        r_spd_fcnt <= r_spd_fcnt + 4'd1;
      end
    end
  end

  assign spd_valid       = r_spd_valid;
  assign spd_update      = r_spd_update;
  assign spd_stale       = (r_spd_fcnt == STALE_LIMIT);
  assign spd_vendor      = r_spd_vendor;
  assign spd_product     = r_spd_product;
  assign spd_source_info = r_spd_source;
`else
  assign spd_valid       = 1'b0;
  assign spd_update      = 1'b0;
  assign spd_stale       = 1'b0;
  assign spd_vendor      = '0;
  assign spd_product     = '0;
  assign spd_source_info = '0;
`endif

endmodule

// File: tb/tb_info_frame_receiver.sv
// Directed self-checking bench for info_frame_receiver (default STALE_FIELDS=2, CNT_WIDTH=8).
module tb_info_frame_receiver;

  logic              clk_pixel = 1'b0;
  logic              reset;
  logic              video_field_end;
  logic              packet_valid;
  logic [23:0]       header;
  logic [3:0][55:0]  sub;
  logic              busy, avi_update, spd_update, avi_valid, spd_valid, avi_stale, spd_stale;
  logic [6:0]        avi_vic;
  logic [1:0]        avi_color_space, avi_picture_aspect;
  logic              avi_it_content;
  logic [63:0]       spd_vendor;
  logic [127:0]      spd_product;
  logic [7:0]        spd_source_info;
  logic [7:0]        checksum_err_count, drop_count;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;

  always #5 clk_pixel = ~clk_pixel;

  info_frame_receiver #(.STALE_FIELDS(2), .CNT_WIDTH(8)) dut (
    .clk_pixel          (clk_pixel),
    .reset              (reset),
    .video_field_end    (video_field_end),
    .packet_valid       (packet_valid),
    .header             (header),
    .sub                (sub),
    .busy               (busy),
    .avi_update         (avi_update),
    .spd_update         (spd_update),
    .avi_valid          (avi_valid),
    .spd_valid          (spd_valid),
    .avi_stale          (avi_stale),
    .spd_stale          (spd_stale),
    .avi_vic            (avi_vic),
    .avi_color_space    (avi_color_space),
    .avi_picture_aspect (avi_picture_aspect),
    .avi_it_content     (avi_it_content),
    .spd_vendor         (spd_vendor),
    .spd_product        (spd_product),
    .spd_source_info    (spd_source_info),
    .checksum_err_count (checksum_err_count),
    .drop_count         (drop_count)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0][55:0] pack(input logic [27:0][7:0] b);
    logic [3:0][55:0] s;
    for (int unsigned i = 0; i < 4; i++)
      for (int unsigned k = 0; k < 7; k++)
        s[i][8*k +: 8] = b[7*i + k];
    return s;
  endfunction

  // Sends one packet; reports the cycle (1..8 after sampling) of each update pulse and busy per cycle.
  // drop_at/vfe_at inject a repeat packet / field-end pulse sampled at edge E<n> (0 = none).
  task automatic run_frame(input logic [23:0] h, input logic [27:0][7:0] b,
                           input int unsigned drop_at, input int unsigned vfe_at,
                           output int unsigned avi_at, output int unsigned spd_at,
                           output logic [8:0] bmask);
    @(negedge clk_pixel);
    header = h; sub = pack(b); packet_valid = 1'b1;
    @(negedge clk_pixel);
    packet_valid = 1'b0;
    avi_at = 0; spd_at = 0; bmask = '0;
    bmask[0] = busy;
    for (int unsigned n = 1; n <= 8; n++) begin
      if (n == drop_at) packet_valid = 1'b1;
      if (n == vfe_at)  video_field_end = 1'b1;
      @(negedge clk_pixel);
      packet_valid = 1'b0; video_field_end = 1'b0;
      if (avi_update && avi_at == 0) avi_at = n;
      if (spd_update && spd_at == 0) spd_at = n;
      bmask[n] = busy;
    end
  endtask

  task automatic vfe();
    @(negedge clk_pixel);
    video_field_end = 1'b1;
    @(negedge clk_pixel);
    video_field_end = 1'b0;
  endtask

  logic [27:0][7:0] pb;
  int unsigned      a, s, upd_seen;
  logic [8:0]       bm;

  initial begin
    reset = 1'b1; packet_valid = 1'b0; video_field_end = 1'b0; header = '0; sub = '0;
    repeat (3) @(negedge clk_pixel);
    chk("rst_busy", busy, 0);
    chk("rst_avi_valid", avi_valid, 0);
    chk("rst_avi_vic", avi_vic, 0);
    chk("rst_avi_stale", avi_stale, 0);
    chk("rst_err", checksum_err_count, 0);
    chk("rst_drop", drop_count, 0);
    chk("rst_spd_valid", spd_valid, 0);
    chk("rst_spd_vendor", spd_vendor, 0);
    reset = 1'b0;

    // Good AVI, VIC 4
    pb = '0; pb[4] = 8'h04; pb[0] = 8'h6B;
    run_frame(24'h0D0282, pb, 0, 0, a, s, bm);
    chk("t1_upd_at", a, 6);
    chk("t1_busy_mask", bm, 9'h03F);
    chk("t1_vic", avi_vic, 4);
    chk("t1_valid", avi_valid, 1);
    chk("t1_err", checksum_err_count, 0);

    // Bad checksum
    pb[0] = 8'h6C;
    run_frame(24'h0D0282, pb, 0, 0, a, s, bm);
    chk("t2_upd_at", a, 0);
    chk("t2_err", checksum_err_count, 1);
    chk("t2_vic_hold", avi_vic, 4);
    chk("t2_valid", avi_valid, 1);

    // All AVI fields
    pb = '0; pb[1] = 8'h40; pb[2] = 8'h20; pb[3] = 8'h80; pb[4] = 8'h10; pb[0] = 8'h7F;
    run_frame(24'h0D0282, pb, 0, 0, a, s, bm);
    chk("t3_upd_at", a, 6);
    chk("t3_vic", avi_vic, 16);
    chk("t3_cs", avi_color_space, 2);
    chk("t3_aspect", avi_picture_aspect, 2);
    chk("t3_it", avi_it_content, 1);

    // Wrong version, checksum correct
    pb = '0; pb[4] = 8'h04; pb[0] = 8'h6A;
    run_frame(24'h0D0382, pb, 0, 0, a, s, bm);
    chk("t4_upd_at", a, 0);
    chk("t4_err", checksum_err_count, 2);
    chk("t4_vic_hold", avi_vic, 16);

    // Length 28 exceeds maximum
    pb[0] = 8'h5C;
    run_frame(24'h1C0282, pb, 0, 0, a, s, bm);
    chk("t5_upd_at", a, 0);
    chk("t5_err", checksum_err_count, 3);

    // Length 12 below AVI minimum
    pb[0] = 8'h6C;
    run_frame(24'h0C0282, pb, 0, 0, a, s, bm);
    chk("t6_upd_at", a, 0);
    chk("t6_err", checksum_err_count, 4);

    // Bytes above length must not enter the checksum
    pb = '0; pb[4] = 8'h04; pb[14] = 8'h55; pb[27] = 8'hAA; pb[0] = 8'h6B;
    run_frame(24'h0D0282, pb, 0, 0, a, s, bm);
    chk("t7_upd_at", a, 6);
    chk("t7_vic", avi_vic, 4);
    chk("t7_err", checksum_err_count, 4);

    // Null and unknown types are ignored
    run_frame(24'h000000, pb, 0, 0, a, s, bm);
    chk("t8_null_busy", bm, 0);
    run_frame(24'h0D0284, pb, 0, 0, a, s, bm);
    chk("t8_unk_busy", bm, 0);
    chk("t8_err", checksum_err_count, 4);
    chk("t8_drop", drop_count, 0);

    // Second packet while busy (SUB1, then COMMIT)
    pb = '0; pb[4] = 8'h04; pb[0] = 8'h6B;
    run_frame(24'h0D0282, pb, 3, 0, a, s, bm);
    chk("t9_upd_at", a, 6);
    chk("t9_drop", drop_count, 1);
    chk("t9_busy_mask", bm, 9'h03F);
    run_frame(24'h0D0282, pb, 6, 0, a, s, bm);
    chk("t10_upd_at", a, 6);
    chk("t10_drop", drop_count, 2);
    chk("t10_err", checksum_err_count, 4);

    // Staleness
    vfe();
    chk("t11_stale_1", avi_stale, 0);
    vfe();
    chk("t11_stale_2", avi_stale, 1);
    vfe();
    chk("t11_stale_sat", avi_stale, 1);
    run_frame(24'h0D0282, pb, 0, 0, a, s, bm);
    chk("t11_clear", avi_stale, 0);
    vfe(); vfe();
    chk("t11_stale_again", avi_stale, 1);
    run_frame(24'h0D0282, pb, 0, 6, a, s, bm);
    chk("t11_simul_upd_at", a, 6);
    chk("t11_simul_clear", avi_stale, 0);
    vfe();
    chk("t11_after_one", avi_stale, 0);

    // SPD "Unknown", length 25
    pb = '0;
    pb[1] = 8'h55; pb[2] = 8'h6E; pb[3] = 8'h6B; pb[4] = 8'h6E;
    pb[5] = 8'h6F; pb[6] = 8'h77; pb[7] = 8'h6E; pb[0] = 8'h73;
`ifdef INFO_FRAME_RX_SPD_EN
    chk("t12_spd_stale_pre", spd_stale, 1);
    run_frame(24'h190183, pb, 0, 0, a, s, bm);
    chk("t12_spd_upd_at", s, 6);
    chk("t12_busy_mask", bm, 9'h03F);
    chk("t12_vendor", spd_vendor, 64'h006E776F6E6B6E55);
    chk("t12_product", spd_product, 0);
    chk("t12_spd_valid", spd_valid, 1);
    chk("t12_spd_stale", spd_stale, 0);
`else
    chk("t12_spd_stale_pre", spd_stale, 0);
    run_frame(24'h190183, pb, 0, 0, a, s, bm);
    chk("t12_spd_upd_at", s, 0);
    chk("t12_busy_mask", bm, 0);
    chk("t12_vendor", spd_vendor, 0);
    chk("t12_spd_valid", spd_valid, 0);
`endif
    chk("t12_avi_upd_at", a, 0);
    chk("t12_err", checksum_err_count, 4);
    chk("t12_drop", drop_count, 2);

    // Reset while in SUB2
    pb = '0; pb[4] = 8'h04; pb[0] = 8'h6B;
    @(negedge clk_pixel);
    header = 24'h0D0282; sub = pack(pb); packet_valid = 1'b1;
    @(negedge clk_pixel);
    packet_valid = 1'b0;
    repeat (3) @(negedge clk_pixel);
    chk("t13_busy_pre", busy, 1);
    reset = 1'b1;
    @(negedge clk_pixel);
    reset = 1'b0;
    chk("t13_busy", busy, 0);
    chk("t13_avi_valid", avi_valid, 0);
    chk("t13_err", checksum_err_count, 0);
    chk("t13_drop", drop_count, 0);
    chk("t13_vic", avi_vic, 0);
    upd_seen = 0;
    for (int unsigned n = 0; n < 8; n++) begin
      @(negedge clk_pixel);
      if (avi_update || busy) upd_seen++;
    end
    chk("t13_no_commit", upd_seen, 0);
    chk("t13_valid_after", avi_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
